tl_xbar_demux: RTL and testbench
================================

Name: tl_xbar_demux

Overview:
- Downstream stage of the crossbar's per-channel arbiter.
- Takes the single arbitrated TileLink beat stream and routes each message to one of N_SINK slave ports, decoding the address of the first beat.
- Holds the route for all beats of a multi-beat message.
- A 2-entry skid buffer on the input registers the ready path, so the upstream combinational ready chain never reaches the slave ports.

Parameters:
- N_SINK, 4, number of output ports (2..16).
- DATA_W, 100, flat beat width (same packing as the arbiter output).
- ADDR_LSB, 36, bit offset of the 32-bit address field in the beat.
- SEL_LSB, 12, address bit where the sink index field starts; field width is SEL_W = clog2(N_SINK).
- SIZE_LSB, 68, bit offset of the 4-bit log2-bytes size field.
- HASDATA_BIT, 72, bit position of the "message carries data" flag.
- BEAT_BYTES, 8, bytes per data beat (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_i  in  1  input beat valid
- ready_o  out  1  input ready; registered, equals "skid buffer not full"
- data_i  in  DATA_W  input beat
- valid_o  out  N_SINK  per-sink valid, at most one bit set
- ready_i  in  N_SINK  per-sink ready
- data_o  out  DATA_W  beat, broadcast to all sinks
- busy_o  out  1  high while a multi-beat message is mid-route

Behaviour:
- Reset values: ready_o=1, valid_o=0, data_o=0, busy_o=0; buffer empty; state IDLE; beat counter 0.
- Skid buffer (2 entries):
  - Input accepted when valid_i && ready_o.
  - ready_o = count<2, computed from registered state only.
  - Head entry drives the output.
  - Accept and pop in the same cycle keep count unchanged.
  - Latency: first possible output cycle is one cycle after acceptance.
- Header decode (IDLE, head present):
  - beats = HASDATA ? max(1, 2^size / BEAT_BYTES) : 1.
  - size field is saturated at 12 (4 KiB).
  - sel = addr[SEL_LSB +: SEL_W]. If sel >= N_SINK, sel = N_SINK-1 (see the optional feature).
- FSM IDLE:
  - valid_o[sel] = 1.
  - On ready_i[sel]: pop. If beats==1 stay IDLE; else latch sel, set remaining = beats-1, go BURST.
- FSM BURST:
  - valid_o[locked sel] = head valid.
  - Every accepted beat decrements remaining. Reaching 0 returns to IDLE.
  - No address decode is performed on beats inside BURST.
- busy_o = (state==BURST).
- Input contract: beats of one message arrive contiguous. The block only counts beats.
- valid_o is never withdrawn before its handshake; data_o is stable while valid_o is high and ready_i is low.
- ready_i of non-selected sinks is ignored.
- Back-to-back single-beat messages to different sinks: one message per cycle, no bubble.
- Reset mid-burst: all state cleared immediately; any partially delivered message is abandoned.

Optional Feature:
- Macro TL_DEMUX_DECERR_EN.
- When defined, a header with sel >= N_SINK is a decode error:
  - All beats of that message are popped without asserting any valid_o, one beat per cycle.
  - Sticky output decerr_o (1 bit) is set; it clears only on rst.
  - Output decerr_cnt_o (8 bits, saturating) counts dropped messages.
- When undefined:
  - Out-of-range sel folds to N_SINK-1.
  - decerr_o and decerr_cnt_o ports are absent.

Decomposition:
- Shared package tl_xbar_pkg:
  - field offset constants (ADDR_LSB, SIZE_LSB, HASDATA_BIT);
  - MAX_LOG_SIZE=12;
  - beat-count function beats_of(size, hasdata, BEAT_BYTES);
  - FSM state typedef {IDLE, BURST}.
- One sub-module: tl_skid_buf (2-entry, parameter DATA_W), reusable on every crossbar channel.

Test Plan:
- Reset then single beat: addr=0x2000, size=3, hasdata=0, with ready_i=4'b1111 -> valid_o=4'b0100 one cycle after acceptance; data_o equals the input beat; busy_o=0.
- Burst: size=5, hasdata=1, BEAT_BYTES=8, addr=0x1000 -> 4 beats on sink 1. Beats 2-4 carry addr=0x3000, yet all go to sink 1; busy_o is high from the cycle after the first handshake until the last beat's handshake; then IDLE.
- Backpressure: ready_i[1]=0 for 5 cycles during a burst -> ready_o falls after 2 buffered beats; data_o stays stable; no beat lost or duplicated (scoreboard).
- Throughput: alternating single-beat messages to sinks 0 and 3, all readies high -> one beat per cycle after the first; valid_o alternates 0001/1000.
- Reset asserted during beat 2 of a 4-beat burst -> next cycle valid_o=0, ready_o=1, busy_o=0. A new header after reset is routed by its own address.
- N_SINK=3: header with sel=3 -> without TL_DEMUX_DECERR_EN it goes to sink 2. With the macro, its 2 beats are popped silently, decerr_o=1, decerr_cnt_o=1.

Source files
------------

// File: rtl/tl_xbar_pkg.sv
// Shared crossbar definitions: beat field offsets, the burst-length helper and
// the demux FSM state type.
package tl_xbar_pkg;

    localparam int TL_ADDR_LSB    = 36;
    localparam int TL_SIZE_LSB    = 68;
    localparam int TL_HASDATA_BIT = 72;
    localparam int MAX_LOG_SIZE   = 12;
    localparam int BEATS_W        = MAX_LOG_SIZE + 1;

    typedef enum logic {
        IDLE,
        BURST
    } demux_state_e;

    // Beats in a message. The size field is clamped to 4 KiB, and a message
    // smaller than one data beat still occupies one beat.
    function automatic logic [BEATS_W-1:0] beats_of(
        input logic [3:0] size,
        input logic       hasdata,
        input int         beat_bytes
    );
        int lg;
        int s;
        lg = 0;
        for (int i = 0; i <= MAX_LOG_SIZE; i++) begin
            if ((1 << i) == beat_bytes) lg = i;
        end
        s = (int'(size) > MAX_LOG_SIZE) ? MAX_LOG_SIZE : int'(size);
        if (!hasdata || s <= lg) return BEATS_W'(1);
        return BEATS_W'(1) << (s - lg);
    endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// Two-entry skid buffer. in_ready_o depends only on the occupancy register, so
// the ready path seen upstream is cut from the downstream ready inputs.
module tl_skid_buf #(
    parameter int DATA_W = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DATA_W-1:0] mem0_q;
    logic [DATA_W-1:0] mem1_q;
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              push;
    logic              pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = rd_q ? mem1_q : mem0_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_q) mem1_q <= in_data_i;
                else      mem0_q <= in_data_i;
                wr_q <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tl_xbar_demux.sv
// Routes the arbitrated TileLink beat stream to one of N_SINK slave ports,
// holding the route for multi-beat messages. Macro TL_DEMUX_DECERR_EN turns
// out-of-range sink indices into silently dropped messages with error status.
module tl_xbar_demux
    import tl_xbar_pkg::*;
#(
    parameter int N_SINK      = 4,
    parameter int DATA_W      = 100,
    parameter int ADDR_LSB    = TL_ADDR_LSB,
    parameter int SEL_LSB     = 12,
    parameter int SIZE_LSB    = TL_SIZE_LSB,
    parameter int HASDATA_BIT = TL_HASDATA_BIT,
    parameter int BEAT_BYTES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [N_SINK-1:0] valid_o,
    input  logic [N_SINK-1:0] ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
`ifdef TL_DEMUX_DECERR_EN
    ,
    output logic              decerr_o,
    output logic [7:0]        decerr_cnt_o
`endif
);

    localparam int SEL_W = $clog2(N_SINK);

    logic               head_valid;
    logic               head_ready;
    logic [DATA_W-1:0]  head_data;
    logic [SEL_W-1:0]   sel_raw;
    logic [SEL_W-1:0]   dec_sel;
    logic [SEL_W-1:0]   route_sel;
    logic [SEL_W-1:0]   sel_q;
    logic [3:0]         hdr_size;
    logic               hdr_hasdata;
    logic [BEATS_W-1:0] hdr_beats;
    logic [BEATS_W-1:0] rem_q;
    logic               drop;
    logic               pop;
    logic               busy_q;
    demux_state_e       state_q;

    tl_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (valid_i),
        .in_ready_o (ready_o),
        .in_data_i  (data_i),
        .out_valid_o(head_valid),
        .out_ready_i(head_ready),
        .out_data_o (head_data)
    );

    // Header fields are only meaningful in IDLE; BURST ignores them.
    assign sel_raw     = head_data[ADDR_LSB + SEL_LSB +: SEL_W];
    assign hdr_size    = head_data[SIZE_LSB +: 4];
    assign hdr_hasdata = head_data[HASDATA_BIT];
    assign hdr_beats   = beats_of(hdr_size, hdr_hasdata, BEAT_BYTES);
    assign dec_sel     = (int'(sel_raw) >= N_SINK) ? SEL_W'(N_SINK - 1) : sel_raw;

`ifdef TL_DEMUX_DECERR_EN
    logic       dec_err;
    logic       drop_q;
    logic       decerr_q;
    logic [7:0] decerr_cnt_q;

    assign dec_err = (int'(sel_raw) >= N_SINK);
    assign drop    = (state_q == IDLE) ? dec_err : drop_q;
`else
    assign drop    = 1'b0;
`endif

    assign route_sel  = (state_q == IDLE) ? dec_sel : sel_q;
    assign head_ready = drop || ready_i[route_sel];
    assign pop        = head_valid && head_ready;
    assign data_o     = head_data;
    assign busy_o     = busy_q;

    always_comb begin
        valid_o = '0;
        if (head_valid && !drop) valid_o[route_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sel_q   <= '0;
            rem_q   <= '0;
`ifdef TL_DEMUX_DECERR_EN
            drop_q  <= 1'b0;
`endif
        end else if (pop) begin
            if (state_q == IDLE) begin
                if (hdr_beats != BEATS_W'(1)) begin
                    state_q <= BURST;
                    busy_q  <= 1'b1;
                    sel_q   <= dec_sel;
                    rem_q   <= hdr_beats - BEATS_W'(1);
`ifdef TL_DEMUX_DECERR_EN
                    drop_q  <= dec_err;
`endif
                end
            end else begin
                rem_q <= rem_q - BEATS_W'(1);
                if (rem_q == BEATS_W'(1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifdef TL_DEMUX_DECERR_EN
                    drop_q  <= 1'b0;
`endif
                end
            end
        end
    end

`ifdef TL_DEMUX_DECERR_EN
    // A dropped message is counted once, when its header leaves the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decerr_q     <= 1'b0;
            decerr_cnt_q <= 8'd0;
        end else if (pop && (state_q == IDLE) && dec_err) begin
            decerr_q <= 1'b1;
            if (decerr_cnt_q != 8'hFF) decerr_cnt_q <= decerr_cnt_q + 8'd1;
        end
    end

    assign decerr_o     = decerr_q;
    assign decerr_cnt_o = decerr_cnt_q;
`endif

endmodule

// File: tb/tb_tl_xbar_demux.sv
// Directed bench for tl_xbar_demux: a 4-sink instance for routing, bursts,
// backpressure, throughput and reset, plus a 3-sink instance for out-of-range
// sink indices.
module tb_tl_xbar_demux;

    localparam int DW = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic [3:0]    valid_o;
    logic [3:0]    ready_i;
    logic [DW-1:0] data_o;
    logic          busy_o;

    logic          v3_i;
    logic          rdy3_o;
    logic [DW-1:0] d3_i;
    logic [2:0]    vo3;
    logic [2:0]    r3_i;
    logic [DW-1:0] do3;
    logic          busy3;

`ifdef TL_DEMUX_DECERR_EN
    logic          decerr_o;
    logic [7:0]    decerr_cnt_o;
    logic          decerr3;
    logic [7:0]    decerr_cnt3;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] C[4];
    logic [DW-1:0] B[4];

    always #5 clk = ~clk;

    tl_xbar_demux #(.N_SINK(4)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .busy_o(busy_o)
`ifdef TL_DEMUX_DECERR_EN
        , .decerr_o(decerr_o), .decerr_cnt_o(decerr_cnt_o)
`endif
    );

    tl_xbar_demux #(.N_SINK(3)) dut3 (
        .clk(clk), .rst(rst),
        .valid_i(v3_i), .ready_o(rdy3_o), .data_i(d3_i),
        .valid_o(vo3), .ready_i(r3_i), .data_o(do3),
        .busy_o(busy3)
`ifdef TL_DEMUX_DECERR_EN
        , .decerr_o(decerr3), .decerr_cnt_o(decerr_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] addr, input logic [3:0] size,
                                         input logic hd, input logic [35:0] pl);
        logic [DW-1:0] b;
        b = '0;
        b[35:0]  = pl;
        b[67:36] = addr;
        b[71:68] = size;
        b[72]    = hd;
        return b;
    endfunction

    // Record any handshake on the 4-sink instance, then advance one cycle.
    task automatic step();
        if (|(valid_o & ready_i)) rx_q.push_back(data_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] g0;
        logic [DW-1:0] g1;
        int idx;
        logic acc;

        rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 4'b1111;
        v3_i = 1'b0; d3_i = '0; r3_i = 3'b111;
        @(posedge clk); #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        step();

        // Single beat to sink 2
        a = mk(32'h2000, 4'd3, 1'b0, 36'hA1);
        valid_i = 1'b1; data_i = a;
        step();
        valid_i = 1'b0;
        chk("single_valid", valid_o, 4'b0100);
        chk("single_data", data_o, a);
        chk("single_busy", busy_o, 0);
        step();
        chk("single_done", valid_o, 0);

        // 4-beat burst, trailing beats carry a different address
        B[0] = mk(32'h1000, 4'd5, 1'b1, 36'hB0);
        for (int i = 1; i < 4; i++) B[i] = mk(32'h3000, 4'd5, 1'b1, 36'hB0 + 36'(i));
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = B[i];
            step();
            chk("burst_valid", valid_o, 4'b0010);
            chk("burst_data", data_o, B[i]);
            chk("burst_busy", busy_o, (i != 0));
        end
        valid_i = 1'b0;
        step();
        chk("burst_end_valid", valid_o, 0);
        chk("burst_end_busy", busy_o, 0);

        // Backpressure on sink 1 during a burst
        for (int i = 0; i < 4; i++) C[i] = mk(32'h1000, 4'd5, 1'b1, 36'hC0 + 36'(i));
        rx_q.delete();
        valid_i = 1'b1; data_i = C[0];
        step();
        ready_i = 4'b1101; data_i = C[1];
        step();
        chk("bp_full", ready_o, 0);
        data_i = C[2];
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_ready_low", ready_o, 0);
            chk("bp_data_stable", data_o, C[0]);
            chk("bp_valid_held", valid_o, 4'b0010);
        end
        ready_i = 4'b1111;
        idx = 2;
        for (int k = 0; k < 20 && rx_q.size() < 4; k++) begin
            if (idx < 4) begin valid_i = 1'b1; data_i = C[idx]; end
            else valid_i = 1'b0;
            acc = valid_i && ready_o;
            step();
            if (acc) idx++;
        end
        valid_i = 1'b0;
        chk("bp_rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) chk("bp_rx_beat", rx_q[i], C[i]);
        end
        step();
        chk("bp_idle_busy", busy_o, 0);
        chk("bp_idle_valid", valid_o, 0);

        // Back-to-back singles alternating sinks 0 and 3
        for (int i = 0; i < 6; i++) begin
            a = mk((i % 2 == 0) ? 32'h0000 : 32'h3000, 4'd2, 1'b0, 36'hD0 + 36'(i));
            valid_i = 1'b1; data_i = a;
            step();
            chk("tp_valid", valid_o, (i % 2 == 0) ? 4'b0001 : 4'b1000);
            chk("tp_data", data_o, a);
            chk("tp_ready", ready_o, 1);
        end
        valid_i = 1'b0;
        step();
        chk("tp_drain", valid_o, 0);

        // Reset during beat 2 of a burst to sink 2
        valid_i = 1'b1; data_i = mk(32'h2000, 4'd5, 1'b1, 36'hE0);
        step();
        data_i = mk(32'h2000, 4'd5, 1'b1, 36'hE1);
        step();
        chk("mid_busy", busy_o, 1);
        chk("mid_valid", valid_o, 4'b0100);
        valid_i = 1'b0; rst = 1'b1;
        step();
        chk("mrst_valid", valid_o, 0);
        chk("mrst_ready", ready_o, 1);
        chk("mrst_busy", busy_o, 0);
        rst = 1'b0;
        a = mk(32'h3000, 4'd3, 1'b0, 36'hF0);
        valid_i = 1'b1; data_i = a;
        step();
        valid_i = 1'b0;
        chk("post_rst_valid", valid_o, 4'b1000);
        chk("post_rst_data", data_o, a);
        chk("post_rst_busy", busy_o, 0);
        step();
        chk("post_rst_drain", valid_o, 0);

        // 3-sink instance: sink index 3 is out of range, 2-beat message
        g0 = mk(32'h3000, 4'd4, 1'b1, 36'h90);
        g1 = mk(32'h3000, 4'd4, 1'b1, 36'h91);
        v3_i = 1'b1; d3_i = g0;
        @(posedge clk); #1;
`ifdef TL_DEMUX_DECERR_EN
        chk("oor_g0_valid", vo3, 3'b000);
`else
        chk("oor_g0_valid", vo3, 3'b100);
        chk("oor_g0_data", do3, g0);
`endif
        d3_i = g1;
        @(posedge clk); #1;
        v3_i = 1'b0;
`ifdef TL_DEMUX_DECERR_EN
        chk("oor_g1_valid", vo3, 3'b000);
`else
        chk("oor_g1_valid", vo3, 3'b100);
        chk("oor_g1_data", do3, g1);
`endif
        chk("oor_busy", busy3, 1);
        @(posedge clk); #1;
        chk("oor_end_valid", vo3, 3'b000);
        chk("oor_end_busy", busy3, 0);
        chk("oor_end_ready", rdy3_o, 1);
`ifdef TL_DEMUX_DECERR_EN
        chk("oor_decerr", decerr3, 1);
        chk("oor_decerr_cnt", decerr_cnt3, 1);
        chk("main_decerr", decerr_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
